// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM with a programmable access latency and byte/half/word
// lanes. Define DMEM_UNALIGNED_TRAP_EN to make misaligned half/word accesses complete with err = 1.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        stall,
    output logic        err
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        we_q, sext_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q;
    logic        ack_q, err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic          access, misaligned;
    logic [3:0]    be;
    logic [31:0]   wd, word, load_val;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic          unused_addr;

    // Upper address bits alias onto the RAM.
    assign idx         = addr_q[AW+1:2];
    assign unused_addr = ^addr_q[31:AW+2];
    assign access      = (state_q == StWait) && (cnt_q == 4'd0);

`ifdef DMEM_UNALIGNED_TRAP_EN
    assign misaligned = ((size_q == 2'b01) && addr_q[0]) ||
                        (size_q[1] && (addr_q[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        be = 4'hf;
        wd = wdata_q;
        case (size_q)
            2'b00: begin
                be = 4'b0001 << addr_q[1:0];
                wd = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be = addr_q[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_q[15:0]}};
            end
            default: begin
                be = 4'hf;
                wd = wdata_q;
            end
        endcase
    end

    assign word   = mem[idx];
    assign lane_b = word[{addr_q[1:0], 3'b000} +: 8];
    assign lane_h = addr_q[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_val = word;
        case (size_q)
            2'b00:   load_val = {{24{sext_q & lane_b[7]}}, lane_b};
            2'b01:   load_val = {{16{sext_q & lane_h[15]}}, lane_h};
            default: load_val = word;
        endcase
    end

    // Reset in the access cycle must suppress the store.
    always_ff @(posedge clk) begin
        if (access && we_q && !misaligned && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        sext_q  <= sext;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt_q   <= 4'(LATENCY - 1);
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        if (!we_q) rdata_q <= misaligned ? 32'h0 : load_val;
                        err_q   <= misaligned;
                        ack_q   <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign stall = req & ~ack_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver queues expected responses, a monitor checks
// every ack. Expectations follow DMEM_UNALIGNED_TRAP_EN when it is defined.
module tb_dmem_responder;
    localparam int unsigned LAT = 2;

    logic        clk, rst, req, we, sext;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata;
    logic        ack, stall, err;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .stall(stall), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] held = 32'h0;

    always @(negedge clk) begin
        if (!rst && ack) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_ack: got ack=1 rdata=%h, required no ack", rdata);
            end else begin
                mon_e = sb.pop_front();
                if (rdata !== mon_e.rdata || err !== mon_e.err) begin
                    fails++;
                    $display("FAIL response: got rdata=%h err=%b, required rdata=%h err=%b",
                             rdata, err, mon_e.rdata, mon_e.err);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic do_req(input string name, input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_r, input logic exp_e);
        exp_t tmp;
        bit   ok, done;
        int   k;
        if (!w) held = exp_e ? 32'h0 : exp_r;
        tmp.rdata = held;
        tmp.err   = exp_e;
        sb.push_back(tmp);
        we = w; size = sz; sext = sx; addr = a; wdata = wd; req = 1'b1;
        if (ack) @(negedge clk);
        #1;
        ok   = stall && !ack;
        k    = 0;
        done = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
            if (ack) begin
                done = 1;
                if (k != LAT + 1 || stall) ok = 0;
            end else if (!stall) begin
                ok = 0;
            end
        end
        req = 1'b0;
        tests++;
        if (!ok || !done) begin
            fails++;
            $display("FAIL timing_%s: ack in cycle %0d (done=%0b), required cycle %0d with stall",
                     name, k, done, LAT + 1);
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_rdata", rdata, 32'h0);
        check("reset_ack", {31'h0, ack}, 32'h0);
        check("reset_err", {31'h0, err}, 32'h0);
        check("reset_stall", {31'h0, stall}, 32'h0);

        do_req("st_w",   1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        do_req("ld_w",   0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        repeat (3) @(negedge clk);
        do_req("clr10",  1, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0);
        do_req("st_b",   1, 2'b00, 0, 32'h13, 32'h00000080, 32'h0, 0);
        do_req("ld_bs",  0, 2'b00, 1, 32'h13, 32'h0, 32'hFFFFFF80, 0);
        do_req("ld_bz",  0, 2'b00, 0, 32'h13, 32'h0, 32'h00000080, 0);
        do_req("ld_w10", 0, 2'b10, 0, 32'h10, 32'h0, 32'h80000000, 0);
        do_req("ld_hz",  0, 2'b01, 0, 32'h12, 32'h0, 32'h00008000, 0);
        do_req("ld_b12", 0, 2'b00, 1, 32'h12, 32'h0, 32'h00000000, 0);

        do_req("clr20",  1, 2'b10, 0, 32'h20, 32'h0, 32'h0, 0);
        do_req("st_h",   1, 2'b01, 0, 32'h22, 32'h0000BEEF, 32'h0, 0);
        do_req("ld_hs",  0, 2'b01, 1, 32'h22, 32'h0, 32'hFFFFBEEF, 0);
        do_req("ld_w20", 0, 2'b10, 0, 32'h20, 32'h0, 32'hBEEF0000, 0);

        do_req("st_wrap", 1, 2'b10, 0, 32'h1000, 32'h12345678, 32'h0, 0);
        do_req("ld_wrap", 0, 2'b11, 1, 32'h0000, 32'h0, 32'h12345678, 0);

`ifdef DMEM_UNALIGNED_TRAP_EN
        do_req("ld_mis",  0, 2'b10, 0, 32'h11, 32'h0, 32'h0, 1);
        do_req("ld_al",   0, 2'b10, 0, 32'h10, 32'h0, 32'h80000000, 0);
        do_req("st_hmis", 1, 2'b01, 0, 32'h21, 32'h00001234, 32'h0, 1);
        do_req("ld_w20b", 0, 2'b10, 0, 32'h20, 32'h0, 32'hBEEF0000, 0);
`else
        do_req("ld_mis",  0, 2'b10, 0, 32'h11, 32'h0, 32'h80000000, 0);
        do_req("ld_al",   0, 2'b10, 0, 32'h10, 32'h0, 32'h80000000, 0);
        do_req("st_hmis", 1, 2'b01, 0, 32'h21, 32'h00001234, 32'h0, 0);
        do_req("ld_w20b", 0, 2'b10, 0, 32'h20, 32'h0, 32'hBEEF1234, 0);
`endif

        do_req("st40", 1, 2'b10, 0, 32'h40, 32'h11223344, 32'h0, 0);
        do_req("st44", 1, 2'b10, 0, 32'h44, 32'h66778899, 32'h0, 0);
        do_req("ld44", 0, 2'b10, 0, 32'h44, 32'h0, 32'h66778899, 0);

        // Abort a store while waiting.
        we = 1'b1; size = 2'b10; sext = 1'b0; addr = 32'h40; wdata = 32'hAAAAAAAA; req = 1'b1;
        if (ack) @(negedge clk);
        @(negedge clk);
        rst = 1'b1; req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        held = 32'h0;
        check("abort_ack", {31'h0, ack}, 32'h0);
        check("abort_rdata", rdata, 32'h0);
        check("abort_err", {31'h0, err}, 32'h0);
        repeat (4) @(negedge clk);

        // Abort a store in its access cycle.
        we = 1'b1; size = 2'b10; addr = 32'h44; wdata = 32'h55555555; req = 1'b1;
        repeat (LAT) @(negedge clk);
        rst = 1'b1; req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        do_req("ld40_kept", 0, 2'b10, 0, 32'h40, 32'h0, 32'h11223344, 0);
        do_req("ld44_kept", 0, 2'b10, 0, 32'h44, 32'h0, 32'h66778899, 0);
        repeat (3) @(negedge clk);
        check("rdata_held", rdata, 32'h66778899);
        check("queue_empty", sb.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end
endmodule
